// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serialises one host request into a command byte frame and collects the response.
// Latency: first TX byte the cycle after accept, 1 byte/cycle when TX_READY is held high,
//   and CMD_DONE one cycle after the last TX byte (write) or after the last RX byte.
// Backpressure: TX stalls indefinitely on !TX_READY with TX_DATA held; RX has none (strobe only).
// Ports: CLK/RST (async active-low); CMD_* request (valid/ready); TX_* byte out (valid/ready);
//   RX_* byte in (strobe); CMD_DONE pulse, RSP_DATA, TIMEOUT_ERR, BUSY status.
module sys_cmd_master #(
  parameter int Address_Width  = 4,
  parameter int Timeout_Cycles = 4096,
  parameter int Data_Width     = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_TYPE,
  input  logic [Address_Width-1:0] CMD_ADDR,
  input  logic [Data_Width-1:0]    CMD_DATA_A,
  input  logic [Data_Width-1:0]    CMD_DATA_B,
  input  logic [3:0]               CMD_FUN,
  output logic [Data_Width-1:0]    TX_DATA,
  output logic                     TX_VALID,
  input  logic                     TX_READY,
  input  logic [Data_Width-1:0]    RX_DATA,
  input  logic                     RX_VALID,
  output logic                     CMD_DONE,
  output logic [15:0]              RSP_DATA,
  output logic                     TIMEOUT_ERR,
  output logic                     BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_LO, S_WAIT_HI} state_t;

  localparam logic [1:0] T_WR = 2'd0, T_RD = 2'd1, T_ALU = 2'd2, T_ALU0 = 2'd3;

  // Counter only needs to reach Timeout_Cycles-1.
  localparam int CW   = (Timeout_Cycles > 1) ? $clog2(Timeout_Cycles) : 1;
  localparam int TLIM = (Timeout_Cycles > 0) ? Timeout_Cycles - 1 : 0;
  localparam logic [CW-1:0] TMAX = TLIM[CW-1:0];

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_type, w_type_nxt;
  logic [Address_Width-1:0] r_addr, w_addr_nxt;
  logic [Data_Width-1:0]   r_a, w_a_nxt, r_b, w_b_nxt;
  logic [3:0]              r_fun, w_fun_nxt;
  logic [1:0]              r_idx, w_idx_nxt;
  logic [Data_Width-1:0]   r_tx_data, w_tx_data_nxt;
  logic                    r_tx_valid, w_tx_valid_nxt;
  logic                    r_done, w_done_nxt;
  logic [15:0]             r_rsp, w_rsp_nxt;
  logic                    r_tout, w_tout_nxt;
  logic [Data_Width-1:0]   r_lo, w_lo_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;

  logic [Data_Width-1:0]   w_hdr;
  logic [Data_Width-1:0]   w_next_byte;
  logic [1:0]              w_last_idx;
  logic [1:0]              w_idx_inc;
  logic                    w_tmo;

  assign w_idx_inc = r_idx + 2'd1;
  assign w_tmo     = (Timeout_Cycles > 0) && (r_cnt == TMAX);

  // Header byte comes straight from the request inputs so it can load on the accept edge.
  always_comb begin
    w_hdr = Data_Width'(8'hAA);
    case (CMD_TYPE)
      T_WR:    w_hdr = Data_Width'(8'hAA);
      T_RD:    w_hdr = Data_Width'(8'hBB);
      T_ALU:   w_hdr = Data_Width'(8'hCC);
      default: w_hdr = Data_Width'(8'hDD);
    endcase
  end

  // Payload byte following the one currently on TX, from the latched request.
  always_comb begin
    w_next_byte = '0;
    w_last_idx  = 2'd1;
    case (r_type)
      T_WR: begin
        w_last_idx  = 2'd2;
        w_next_byte = (w_idx_inc == 2'd1) ? Data_Width'(r_addr) : r_a;
      end
      T_RD: begin
        w_last_idx  = 2'd1;
        w_next_byte = Data_Width'(r_addr);
      end
      T_ALU: begin
        w_last_idx  = 2'd3;
        case (w_idx_inc)
          2'd1:    w_next_byte = r_a;
          2'd2:    w_next_byte = r_b;
          default: w_next_byte = Data_Width'(r_fun);
        endcase
      end
      default: begin
        w_last_idx  = 2'd1;
        w_next_byte = Data_Width'(r_fun);
      end
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_type_nxt     = r_type;
    w_addr_nxt     = r_addr;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_fun_nxt      = r_fun;
    w_idx_nxt      = r_idx;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_done_nxt     = 1'b0;
    w_rsp_nxt      = r_rsp;
    w_tout_nxt     = r_tout;
    w_lo_nxt       = r_lo;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (CMD_VALID) begin
          w_type_nxt     = CMD_TYPE;
          w_addr_nxt     = CMD_ADDR;
          w_a_nxt        = CMD_DATA_A;
          w_b_nxt        = CMD_DATA_B;
          w_fun_nxt      = CMD_FUN;
          w_tout_nxt     = 1'b0;
          w_idx_nxt      = 2'd0;
          w_tx_data_nxt  = w_hdr;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (r_tx_valid && TX_READY) begin
          if (r_idx == w_last_idx) begin
            w_tx_valid_nxt = 1'b0;
            w_cnt_nxt      = '0;
            if (r_type == T_WR) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_rsp_nxt   = '0;
            end else begin
              w_state_nxt = S_WAIT_LO;
            end
          end else begin
            // Reload on the accept edge so TX_VALID never drops mid-frame.
            w_idx_nxt     = w_idx_inc;
            w_tx_data_nxt = w_next_byte;
          end
        end
      end
      S_WAIT_LO: begin
        if (RX_VALID) begin
          w_lo_nxt  = RX_DATA;
          w_cnt_nxt = '0;
          if (r_type == T_RD) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_rsp_nxt   = {{Data_Width{1'b0}}, RX_DATA};
          end else begin
            w_state_nxt = S_WAIT_HI;
          end
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_tout_nxt  = 1'b1;
          w_rsp_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        // A byte arriving on the limit cycle still wins over the timeout.
        if (RX_VALID) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_rsp_nxt   = {RX_DATA, r_lo};
          w_cnt_nxt   = '0;
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_tout_nxt  = 1'b1;
          w_rsp_nxt   = {{Data_Width{1'b0}}, r_lo};
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_type     <= '0;
      r_addr     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_fun      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rsp      <= '0;
      r_tout     <= 1'b0;
      r_lo       <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_type     <= w_type_nxt;
      r_addr     <= w_addr_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_fun      <= w_fun_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_done     <= w_done_nxt;
      r_rsp      <= w_rsp_nxt;
      r_tout     <= w_tout_nxt;
      r_lo       <= w_lo_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign CMD_READY   = (r_state == S_IDLE);
  assign BUSY        = (r_state != S_IDLE);
  assign TX_DATA     = r_tx_data;
  assign TX_VALID    = r_tx_valid;
  assign CMD_DONE    = r_done;
  assign RSP_DATA    = r_rsp;
  assign TIMEOUT_ERR = r_tout;

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: directed and randomized checks of sys_cmd_master against a frame/response model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Wait-phase timing is expressed as an index of falling edges after the last TX handshake is pending.
module tb_sys_cmd_master;
  localparam int T = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_TYPE = '0;
  logic [3:0] CMD_ADDR = '0;
  logic [7:0] CMD_DATA_A = '0, CMD_DATA_B = '0;
  logic [3:0] CMD_FUN = '0;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY = 1'b0;
  logic [7:0] RX_DATA = '0;
  logic       RX_VALID = 1'b0;
  logic       CMD_DONE;
  logic [15:0] RSP_DATA;
  logic       TIMEOUT_ERR;
  logic       BUSY;

  sys_cmd_master #(.Address_Width(4), .Timeout_Cycles(T), .Data_Width(8)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_DATA_A(CMD_DATA_A),
    .CMD_DATA_B(CMD_DATA_B), .CMD_FUN(CMD_FUN), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .CMD_DONE(CMD_DONE), .RSP_DATA(RSP_DATA),
    .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_exp[$];
  logic [7:0] got[$];
  int o_stall, o_gap, o_busy, o_done_i, o_tx_err;
  logic o_first_v, o_first_tout, o_tout, o_rdy, o_busy_at_done, o_txv;
  logic [7:0] o_first_d;
  logic [15:0] o_rsp;

  // Expected frame, built directly from the frame layout table.
  task automatic model_frame(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                             input logic [7:0] b, input logic [3:0] f);
    case (t)
      2'd0: m_exp = '{8'hAA, {4'h0, ad}, a};
      2'd1: m_exp = '{8'hBB, {4'h0, ad}};
      2'd2: m_exp = '{8'hCC, a, b, {4'h0, f}};
      default: m_exp = '{8'hDD, {4'h0, f}};
    endcase
  endtask

  // Expected completion given how many wait cycles elapse before each response byte.
  task automatic model_rsp(input logic [1:0] t, input int dlo, input int dhi,
                           input logic [7:0] lo, input logic [7:0] hi,
                           output int e_done, output logic [15:0] e_rsp, output logic e_tout,
                           output int lo_i, output int hi_i);
    lo_i = -1; hi_i = -1; e_tout = 1'b0; e_rsp = 16'h0000; e_done = 0;
    if (t == 2'd0) e_done = 0;
    else if (dlo >= T) begin e_done = T; e_tout = 1'b1; end
    else begin
      lo_i = dlo;
      if (t == 2'd1) begin e_done = dlo + 1; e_rsp = {8'h00, lo}; end
      else if (dhi >= T) begin e_done = dlo + 1 + T; e_rsp = {8'h00, lo}; e_tout = 1'b1; end
      else begin hi_i = dlo + 1 + dhi; e_done = dlo + dhi + 2; e_rsp = {hi, lo}; end
    end
  endtask

  function automatic bit frame_ok();
    if (got.size() != m_exp.size()) return 1'b0;
    foreach (got[i]) if (got[i] !== m_exp[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] f);
    for (int k = 0; k < 100 && CMD_READY !== 1'b1; k++) @(negedge CLK);
    CMD_VALID = 1'b1; CMD_TYPE = t; CMD_ADDR = ad; CMD_DATA_A = a; CMD_DATA_B = b; CMD_FUN = f;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Returns at the falling edge before the n-th byte's handshake edge.
  task automatic collect(input int n, input int mode, input bit noise);
    bit rdy, pv, pr;
    logic [7:0] pd;
    got.delete(); o_stall = 0; o_gap = 0; o_busy = 0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) @(negedge CLK);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom % 2);
      TX_READY = rdy;
      if (pv && !pr && (TX_VALID !== 1'b1 || TX_DATA !== pd)) o_stall++;
      if (TX_VALID !== 1'b1) o_gap++;
      if (CMD_READY !== 1'b0) o_busy++;
      if (noise) begin
        RX_VALID = 1'($urandom % 2); RX_DATA = 8'($urandom);
        CMD_VALID = 1'($urandom % 2); CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom);
        CMD_DATA_A = 8'($urandom); CMD_DATA_B = 8'($urandom); CMD_FUN = 4'($urandom);
      end
      if (TX_VALID === 1'b1 && rdy) got.push_back(TX_DATA);
      pv = (TX_VALID === 1'b1); pr = rdy; pd = TX_DATA;
      if (got.size() == n) break;
    end
    RX_VALID = 1'b0; CMD_VALID = 1'b0;
  endtask

  task automatic run_wait(input int lo_i, input logic [7:0] lo, input int hi_i, input logic [7:0] hi);
    o_done_i = -1; o_tx_err = 0;
    for (int i = 0; i < 4 * T + 20; i++) begin
      @(negedge CLK);
      if (CMD_DONE === 1'b1) begin o_done_i = i; break; end
      if (TX_VALID !== 1'b0) o_tx_err++;
      RX_VALID = (i == lo_i) || (i == hi_i);
      RX_DATA = (i == hi_i) ? hi : lo;
    end
    RX_VALID = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] f, input int mode, input bit noise,
                        input int lo_i, input logic [7:0] lo, input int hi_i, input logic [7:0] hi);
    model_frame(t, ad, a, b, f);
    send_cmd(t, ad, a, b, f);
    o_first_v = TX_VALID; o_first_d = TX_DATA; o_first_tout = TIMEOUT_ERR;
    collect(m_exp.size(), mode, noise);
    run_wait(lo_i, lo, hi_i, hi);
    o_rsp = RSP_DATA; o_tout = TIMEOUT_ERR; o_rdy = CMD_READY; o_busy_at_done = BUSY; o_txv = TX_VALID;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #1;
    checks++;
    if ({TX_VALID, TX_DATA, CMD_DONE, RSP_DATA, TIMEOUT_ERR, BUSY, CMD_READY} !==
        {1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: txv=%b txd=%h done=%b rsp=%h tout=%b busy=%b rdy=%b, want all 0 and rdy=1",
               TX_VALID, TX_DATA, CMD_DONE, RSP_DATA, TIMEOUT_ERR, BUSY, CMD_READY);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write();
    do_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 4'h0, 0, 1'b0, -1, 8'h00, -1, 8'h00);
    checks++;
    if (o_first_v !== 1'b1 || o_first_d !== 8'hAA) begin
      failures++; $display("FAIL write_first_byte: valid=%b data=%h, want 1/aa", o_first_v, o_first_d);
    end
    checks++;
    if (!frame_ok()) begin failures++; $display("FAIL write_frame: got %p want %p", got, m_exp); end
    checks++;
    if (o_gap != 0) begin failures++; $display("FAIL write_b2b: valid gaps=%0d want 0", o_gap); end
    checks++;
    if (o_done_i != 0) begin failures++; $display("FAIL write_done_time: index=%0d want 0", o_done_i); end
    checks++;
    if (o_rsp !== 16'h0000 || o_tout !== 1'b0 || o_rdy !== 1'b1 || o_busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL write_done_state: rsp=%h tout=%b rdy=%b busy=%b want 0000/0/1/0", o_rsp, o_tout, o_rdy, o_busy_at_done);
    end
    @(negedge CLK);
    checks++;
    if (CMD_DONE !== 1'b0) begin failures++; $display("FAIL write_done_pulse: done=%b want 0", CMD_DONE); end
  endtask

  task automatic test_read();
    do_cmd(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 0, 1'b0, 12, 8'h7E, -1, 8'h00);
    checks++;
    if (!frame_ok()) begin failures++; $display("FAIL read_frame: got %p want %p", got, m_exp); end
    checks++;
    if (o_done_i != 13 || o_tx_err != 0) begin
      failures++; $display("FAIL read_done_time: index=%0d txv_in_wait=%0d want 13/0", o_done_i, o_tx_err);
    end
    checks++;
    if (o_rsp !== 16'h007E || o_tout !== 1'b0 || o_txv !== 1'b0) begin
      failures++; $display("FAIL read_rsp: rsp=%h tout=%b txv=%b want 007e/0/0", o_rsp, o_tout, o_txv);
    end
  endtask

  task automatic test_alu_ops();
    do_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 1, 1'b0, 3, 8'h08, 6, 8'h04);
    checks++;
    if (!frame_ok()) begin failures++; $display("FAIL alu_frame: got %p want %p", got, m_exp); end
    checks++;
    if (o_stall != 0) begin failures++; $display("FAIL alu_stall_stable: violations=%0d want 0", o_stall); end
    checks++;
    if (o_done_i != 7 || o_rsp !== 16'h0408 || o_tout !== 1'b0) begin
      failures++; $display("FAIL alu_rsp: index=%0d rsp=%h tout=%b want 7/0408/0", o_done_i, o_rsp, o_tout);
    end
  endtask

  task automatic test_stray_rx();
    int done_seen, busy_seen;
    done_seen = 0; busy_seen = 0;
    @(negedge CLK);
    for (int k = 0; k < 6; k++) begin
      RX_VALID = 1'b1; RX_DATA = 8'($urandom);
      @(negedge CLK);
      RX_VALID = 1'b0;
      if (CMD_DONE === 1'b1) done_seen++;
      if (BUSY !== 1'b0) busy_seen++;
      @(negedge CLK);
    end
    checks++;
    if (RSP_DATA !== 16'h0408) begin failures++; $display("FAIL stray_rsp: rsp=%h want 0408", RSP_DATA); end
    checks++;
    if (done_seen != 0 || busy_seen != 0) begin
      failures++; $display("FAIL stray_state: done=%0d busy=%0d want 0/0", done_seen, busy_seen);
    end
  endtask

  task automatic test_alu_noops();
    do_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h0, 0, 1'b0, 2, 8'h11, 2 + 1 + (T - 1), 8'h46);
    checks++;
    if (!frame_ok()) begin failures++; $display("FAIL alu0_frame: got %p want %p", got, m_exp); end
    checks++;
    if (o_done_i != 2 + 1 + T || o_rsp !== 16'h4611 || o_tout !== 1'b0) begin
      failures++; $display("FAIL alu0_limit_byte: index=%0d rsp=%h tout=%b want %0d/4611/0", o_done_i, o_rsp, o_tout, 3 + T);
    end
  endtask

  task automatic test_timeout();
    do_cmd(2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 0, 1'b0, -1, 8'h00, -1, 8'h00);
    checks++;
    if (o_done_i != T || o_tout !== 1'b1 || o_rsp !== 16'h0000) begin
      failures++; $display("FAIL timeout_lo: index=%0d tout=%b rsp=%h want %0d/1/0000", o_done_i, o_tout, o_rsp, T);
    end
    @(negedge CLK);
    checks++;
    if (CMD_DONE !== 1'b0 || TIMEOUT_ERR !== 1'b1) begin
      failures++; $display("FAIL timeout_hold: done=%b tout=%b want 0/1", CMD_DONE, TIMEOUT_ERR);
    end
    do_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 0, 1'b0, 4, 8'h5A, -1, 8'h00);
    checks++;
    if (o_first_tout !== 1'b0) begin failures++; $display("FAIL timeout_clear: tout=%b want 0 after accept", o_first_tout); end
    checks++;
    if (o_done_i != 4 + 1 + T || o_tout !== 1'b1 || o_rsp !== 16'h005A) begin
      failures++; $display("FAIL timeout_hi: index=%0d tout=%b rsp=%h want %0d/1/005a", o_done_i, o_tout, o_rsp, 5 + T);
    end
  endtask

  task automatic test_reset_midframe();
    int done_seen, txv_seen;
    done_seen = 0; txv_seen = 0;
    send_cmd(2'd2, 4'h0, 8'hA1, 8'hB2, 4'h9);
    collect(2, 0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
      failures++; $display("FAIL reset_mid: txv=%b busy=%b rdy=%b want 0/0/1", TX_VALID, BUSY, CMD_READY);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (CMD_DONE === 1'b1) done_seen++;
      if (TX_VALID === 1'b1) txv_seen++;
      if (k == 1) RST = 1'b1;
    end
    checks++;
    if (done_seen != 0 || txv_seen != 0) begin
      failures++; $display("FAIL reset_mid_quiet: done=%0d txv=%0d want 0/0", done_seen, txv_seen);
    end
    do_cmd(2'd0, 4'h9, 8'hE7, 8'h00, 4'h0, 0, 1'b0, -1, 8'h00, -1, 8'h00);
    checks++;
    if (!frame_ok() || o_done_i != 0 || o_rsp !== 16'h0000) begin
      failures++; $display("FAIL reset_mid_recover: frame %p want %p index=%0d rsp=%h", got, m_exp, o_done_i, o_rsp);
    end
  endtask

  task automatic test_random();
    logic [1:0] t; logic [3:0] ad, f; logic [7:0] a, b, lo, hi;
    int dlo, dhi, e_done, lo_i, hi_i;
    logic [15:0] e_rsp; logic e_tout;
    for (int n = 0; n < 25; n++) begin
      t = 2'($urandom); ad = 4'($urandom); f = 4'($urandom);
      a = 8'($urandom); b = 8'($urandom); lo = 8'($urandom); hi = 8'($urandom);
      dlo = ($urandom % 5 == 0) ? T - 1 : $urandom_range(0, T + 1);
      dhi = ($urandom % 5 == 0) ? T - 1 : $urandom_range(0, T + 1);
      model_rsp(t, dlo, dhi, lo, hi, e_done, e_rsp, e_tout, lo_i, hi_i);
      do_cmd(t, ad, a, b, f, 2, 1'b1, lo_i, lo, hi_i, hi);
      checks++;
      if (!frame_ok() || o_stall != 0 || o_busy != 0) begin
        failures++; $display("FAIL rand_frame[%0d]: got %p want %p stall=%0d busy_rdy=%0d", n, got, m_exp, o_stall, o_busy);
      end
      checks++;
      if (o_done_i != e_done || o_rsp !== e_rsp || o_tout !== e_tout || o_tx_err != 0) begin
        failures++;
        $display("FAIL rand_rsp[%0d]: type=%0d index=%0d rsp=%h tout=%b txv=%0d want %0d/%h/%b/0",
                 n, t, o_done_i, o_rsp, o_tout, o_tx_err, e_done, e_rsp, e_tout);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_stray_rx();
    test_alu_noops();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
